// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: instruction-fetch stage of the pipelined MIPS core.
// Holds the PC, drives the instruction-memory address and loads the IF/ID
// register. Any redirect (EX branch or ID jump/jr/interrupt/exception)
// loads a bubble into IF/ID, so the instruction at the old PC is dropped.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h80000000,
    parameter logic [31:0] ILLOP     = 32'h80000004,
    parameter logic [31:0] XADR      = 32'h80000008,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  id_pcsrc,
    input  logic [31:0] id_jr_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [2:0]  eff_pcsrc;
    logic        id_redirect;
    logic [31:0] id_target;

    assign imem_addr = pc;

    // The supervisor bit is carried through; only the low 31 bits count up.
    assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

    assign jump_target = {ifid_pc_plus4[31:28], ifid_instruction[25:0], 2'b00};

    // A decoder redirect only counts for a real instruction that is not stalled.
    assign eff_pcsrc = (ifid_valid && !stall) ? id_pcsrc : 3'b000;

    // Decode the effective PCSrc into a redirect flag and its target address.
    always_comb begin
        id_redirect = 1'b0;
        id_target   = pc_plus4;
        case (eff_pcsrc)
            3'b010: begin
                id_redirect = 1'b1;
                id_target   = jump_target;
            end
            3'b011: begin
                id_redirect = 1'b1;
                id_target   = id_jr_target;
            end
            3'b100: begin
                id_redirect = 1'b1;
                id_target   = ILLOP;
            end
            3'b101: begin
                id_redirect = 1'b1;
                id_target   = XADR;
            end
            default: begin
                id_redirect = 1'b0;
                id_target   = pc_plus4;
            end
        endcase
    end

    // PC and IF/ID update: EX branch > ID redirect > stall > sequential fetch.
    // On a bubble ifid_pc/ifid_pc_plus4 hold so the link value stays stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc               <= RESET_PC;
            ifid_instruction <= NOP_INSTR;
            ifid_pc          <= 32'h0;
            ifid_pc_plus4    <= 32'h0;
            ifid_valid       <= 1'b0;
        end else if (ex_branch_taken) begin
            pc               <= ex_branch_target;
            ifid_instruction <= NOP_INSTR;
            ifid_valid       <= 1'b0;
        end else if (id_redirect) begin
            pc               <= id_target;
            ifid_instruction <= NOP_INSTR;
            ifid_valid       <= 1'b0;
        end else if (!stall) begin
            pc               <= pc_plus4;
            ifid_instruction <= imem_rdata;
            ifid_pc          <= pc;
            ifid_pc_plus4    <= pc_plus4;
            ifid_valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed and random stimulus for pc_fetch_stage.
// A behavioural model predicts PC and IF/ID after every clock edge; the
// prediction is queued and a separate monitor compares it after the edge.
module tb_pc_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h80000000;
    localparam logic [31:0] ILLOP    = 32'h80000004;
    localparam logic [31:0] XADR     = 32'h80000008;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  id_pcsrc;
    logic [31:0] id_jr_target;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ip4;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];

    // model state
    logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
    logic        m_valid;

    pc_fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .id_pcsrc         (id_pcsrc),
        .id_jr_target     (id_jr_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .imem_rdata       (imem_rdata),
        .imem_addr        (imem_addr),
        .ifid_instruction (ifid_instruction),
        .ifid_pc          (ifid_pc),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_valid       (ifid_valid)
    );

    always #5 clk = ~clk;

    // Combinational ROM: a j with index 0x10 sits at 80000004, hash elsewhere.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h80000004) return 32'h08000010;
        return {a[15:0], a[31:16]} ^ 32'h3C085A5A;
    endfunction

    assign imem_rdata = rom(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        m_ip4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // Address after a sequential fetch: low 31 bits advance by 4 modulo 2^31,
    // the supervisor bit is untouched.
    function automatic logic [31:0] seq_addr(input logic [31:0] a);
        longint unsigned low;
        low = (longint'(a) % 64'h80000000 + 4) % 64'h80000000;
        return (a & 32'h80000000) | 32'(low);
    endfunction

    // One clock edge of the fetch-stage rules.
    task automatic model_step(input logic st, input logic [2:0] src,
                              input logic [31:0] jr, input logic br,
                              input logic [31:0] bt);
        logic [2:0]  eff;
        logic [31:0] tgt;
        logic        redir;
        eff   = (m_valid && !st) ? src : 3'd0;
        redir = 1'b1;
        case (eff)
            3'd2:    tgt = {m_ip4[31:28], 28'(m_instr[25:0] * 4)};
            3'd3:    tgt = jr;
            3'd4:    tgt = ILLOP;
            3'd5:    tgt = XADR;
            default: begin tgt = 32'h0; redir = 1'b0; end
        endcase
        if (br) begin
            m_pc = bt; m_instr = 32'h0; m_valid = 1'b0;
        end else if (redir) begin
            m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = rom(m_pc);
            m_ipc   = m_pc;
            m_ip4   = seq_addr(m_pc);
            m_pc    = seq_addr(m_pc);
            m_valid = 1'b1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_imem_addr"}, imem_addr, RESET_PC);
        chk({tag, "_instr"}, ifid_instruction, 32'h0);
        chk({tag, "_ifid_pc"}, ifid_pc, 32'h0);
        chk({tag, "_ifid_pc4"}, ifid_pc_plus4, 32'h0);
        chk({tag, "_valid"}, {31'h0, ifid_valid}, 32'h0);
    endtask

    // One stimulus cycle: optional async reset pulse, then drive and predict.
    task automatic cycle(input logic st, input logic [2:0] src, input logic [31:0] jr,
                         input logic br, input logic [31:0] bt, input logic rst_pulse);
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        if (rst_pulse) begin
            reset = 1'b0;
            #1;
            check_reset_values("midreset");
            model_reset();
            #1 reset = 1'b1;
        end
        stall            = st;
        id_pcsrc         = src;
        id_jr_target     = jr;
        ex_branch_taken  = br;
        ex_branch_target = bt;
        model_step(st, src, jr, br, bt);
        e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.ip4 = m_ip4; e.valid = m_valid;
        exp_q.push_back(e);
    endtask

    // Monitor: after each edge, compare DUT state against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr", imem_addr, e.pc);
                chk("ifid_instruction", ifid_instruction, e.instr);
                chk("ifid_pc", ifid_pc, e.ipc);
                chk("ifid_pc_plus4", ifid_pc_plus4, e.ip4);
                chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, e.valid});
            end
        end
    end

    initial begin
        reset            = 1'b0;
        stall            = 1'b0;
        id_pcsrc         = 3'd0;
        id_jr_target     = 32'h0;
        ex_branch_taken  = 1'b0;
        ex_branch_target = 32'h0;
        model_reset();
        #7;
        check_reset_values("reset");
        #10;
        check_reset_values("reset_hold");

        // release and sequential fetch W0, W1 (W1 is the jump)
        cycle(0, 3'd0, 32'h0, 0, 32'h0, 0);
        cycle(0, 3'd0, 32'h0, 0, 32'h0, 0);
        // jump taken from ID -> 80000040, then fetch there
        cycle(0, 3'd2, 32'h0, 0, 32'h0, 0);
        cycle(0, 3'd0, 32'h0, 0, 32'h0, 0);
        cycle(0, 3'd0, 32'h0, 0, 32'h0, 0);
        // branch overrides stall and exception
        cycle(1, 3'd5, 32'h0, 1, 32'h00000100, 0);
        cycle(0, 3'd0, 32'h0, 0, 32'h0, 0);
        // stalled jr is held off, taken once stall drops
        cycle(1, 3'd3, 32'h00002468, 0, 32'h0, 0);
        cycle(1, 3'd3, 32'h00002468, 0, 32'h0, 0);
        cycle(1, 3'd3, 32'h00002468, 0, 32'h0, 0);
        cycle(0, 3'd3, 32'h00002468, 0, 32'h0, 0);
        // interrupt then exception on valid instructions
        cycle(0, 3'd0, 32'h0, 0, 32'h0, 0);
        cycle(0, 3'd4, 32'h0, 0, 32'h0, 0);
        cycle(0, 3'd0, 32'h0, 0, 32'h0, 0);
        cycle(0, 3'd5, 32'h0, 0, 32'h0, 0);
        cycle(0, 3'd0, 32'h0, 0, 32'h0, 0);
        // pcsrc on a bubble is ignored
        cycle(0, 3'd1, 32'h0, 1, 32'h7FFFFFFC, 0);
        cycle(0, 3'd4, 32'h0, 0, 32'h0, 0);
        // 31-bit wrap in both halves of the address space
        cycle(0, 3'd0, 32'h0, 1, 32'h7FFFFFFC, 0);
        cycle(0, 3'd0, 32'h0, 0, 32'h0, 0);
        cycle(0, 3'd0, 32'h0, 1, 32'hFFFFFFFC, 0);
        cycle(0, 3'd0, 32'h0, 0, 32'h0, 0);
        cycle(0, 3'd6, 32'h0, 0, 32'h0, 0);
        cycle(0, 3'd7, 32'h0, 0, 32'h0, 0);
        // async reset in the middle of a stall
        cycle(1, 3'd0, 32'h0, 0, 32'h0, 0);
        cycle(1, 3'd3, 32'h00001000, 0, 32'h0, 1);
        cycle(0, 3'd0, 32'h0, 0, 32'h0, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic        st, br, rp;
            logic [2:0]  src;
            logic [31:0] jr, bt;
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 9) == 0);
            rp  = ($urandom_range(0, 49) == 0);
            src = 3'($urandom_range(0, 7));
            jr  = $urandom() & 32'hFFFFFFFC;
            bt  = $urandom() & 32'hFFFFFFFC;
            cycle(st, src, jr, br, bt, rp);
        end

        @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
